// File: rtl/filter_env_ctrl_pkg.sv
// Shared definitions for the filter cutoff envelope: level width, state
// encodings and small min/max helpers used for the effective limits.
package filter_env_ctrl_pkg;

    localparam int W = 16;

    localparam logic [2:0] ENV_IDLE    = 3'd0;
    localparam logic [2:0] ENV_ATTACK  = 3'd1;
    localparam logic [2:0] ENV_DECAY   = 3'd2;
    localparam logic [2:0] ENV_SUSTAIN = 3'd3;
    localparam logic [2:0] ENV_RELEASE = 3'd4;

    function automatic logic [W-1:0] min_w(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [W-1:0] max_w(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/filter_env_ctrl_step_sat.sv
// Combinational saturating step of a level toward a target (dir=1 rising).
// A zero step, or a level already at/past the target, lands on the target.
module env_step_sat
    import filter_env_ctrl_pkg::*;
(
    input  logic [W-1:0] cur,
    input  logic [W-1:0] step,
    input  logic [W-1:0] target,
    input  logic         dir,
    output logic [W-1:0] next,
    output logic         reached
);

    logic [W:0] gap;
    logic       beyond;

    always_comb begin
        if (dir) begin
            beyond = cur > target;
            gap    = {1'b0, target} - {1'b0, cur};
        end else begin
            beyond = cur < target;
            gap    = {1'b0, cur} - {1'b0, target};
        end
        // gap is only meaningful when not beyond; the OR short-circuits that case
        if (step == '0 || beyond || gap <= {1'b0, step}) begin
            next = target;
        end else if (dir) begin
            next = cur + step;
        end else begin
            next = cur - step;
        end
        reached = (next == target);
    end

endmodule

// File: rtl/filter_env_ctrl.sv
// Attack/decay/sustain/release cutoff envelope producing complementary
// Q0.16 filter coefficients b_out = level, a_out = ~level.
module filter_env_ctrl
    import filter_env_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sample_tick,
    input  logic         gate,
    input  logic [W-1:0] attack_step,
    input  logic [W-1:0] decay_step,
    input  logic [W-1:0] release_step,
    input  logic [W-1:0] sustain_level,
    input  logic [W-1:0] b_min,
    input  logic [W-1:0] b_max,
    output logic [W-1:0] b_out,
    output logic [W-1:0] a_out,
    output logic [2:0]   env_state,
    output logic         active
);

    logic [2:0]   state_reg, state_next;
    logic [W-1:0] level_reg, level_next;
    logic         gate_reg;
    logic         active_reg;

    logic [W-1:0] lo, hi, sus;
    logic [W-1:0] step_sel, target_sel, step_level;
    logic         dir_sel, step_reached;
    logic         rise, fall;

    assign lo   = min_w(b_min, b_max);
    assign hi   = max_w(b_min, b_max);
    assign sus  = min_w(max_w(sustain_level, lo), hi);
    assign rise = gate & ~gate_reg;
    assign fall = ~gate & gate_reg;

    always_comb begin
        step_sel   = '0;
        target_sel = lo;
        dir_sel    = 1'b0;
        case (state_reg)
            ENV_ATTACK: begin
                step_sel   = attack_step;
                target_sel = hi;
                dir_sel    = 1'b1;
            end
            ENV_DECAY: begin
                step_sel   = decay_step;
                target_sel = sus;
                dir_sel    = level_reg < sus;
            end
            ENV_RELEASE: begin
                step_sel   = release_step;
                target_sel = lo;
                dir_sel    = 1'b0;
            end
            default: ;
        endcase
    end

    env_step_sat u_step (
        .cur     (level_reg),
        .step    (step_sel),
        .target  (target_sel),
        .dir     (dir_sel),
        .next    (step_level),
        .reached (step_reached)
    );

    // Gate edges win over the sample tick: the tick in an edge cycle is dropped.
    always_comb begin
        state_next = state_reg;
        level_next = level_reg;
        if (rise) begin
            state_next = ENV_ATTACK;
        end else if (fall) begin
            if (state_reg == ENV_ATTACK || state_reg == ENV_DECAY || state_reg == ENV_SUSTAIN) begin
                state_next = ENV_RELEASE;
            end else if (state_reg != ENV_RELEASE) begin
                state_next = ENV_IDLE;
            end
        end else if (state_reg > ENV_RELEASE) begin
            state_next = ENV_IDLE;
        end else if (sample_tick) begin
            case (state_reg)
                ENV_IDLE:    level_next = lo;
                ENV_SUSTAIN: level_next = sus;
                ENV_ATTACK: begin
                    level_next = step_level;
                    if (step_reached) state_next = ENV_DECAY;
                end
                ENV_DECAY: begin
                    level_next = step_level;
                    if (step_reached) state_next = ENV_SUSTAIN;
                end
                ENV_RELEASE: begin
                    level_next = step_level;
                    if (step_reached) state_next = ENV_IDLE;
                end
                default: state_next = ENV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ENV_IDLE;
            level_reg  <= '0;
            gate_reg   <= 1'b0;
            active_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            level_reg  <= level_next;
            gate_reg   <= gate;
            active_reg <= (state_next != ENV_IDLE);
        end
    end

    assign b_out     = level_reg;
    assign a_out     = ~level_reg;
    assign env_state = state_reg;
    assign active    = active_reg;

endmodule
